// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply / divide, one bit per clock.
//   clk, reset (sync, active-high)
//   start, op[1:0] (00 MUL, 01 MULHU, 10 DIVU, 11 REMU)
//   rs1_data / rs2_data : operand A (dividend) / operand B (divisor)
//   rd_addr             : destination register index
//   busy                : high while CALC or DONE; control stalls on it
//   done                : one-cycle completion pulse
//   result, wb_reg      : final value and destination, held after done
//   wb_en               : register-file write pulse, suppressed for rd==0
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic                  wb_en
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;

  logic [1:0]            op_q;
  logic [XLEN-1:0]       b_q;
  logic [XLEN:0]         acc, acc_n;    // MUL: product high half; DIV: remainder
  logic [XLEN-1:0]       lo, lo_n;      // MUL: multiplier/product low; DIV: dividend/quotient
  logic [CNT_W-1:0]      count;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  div0;
  logic [XLEN-1:0]       result_q, fin;

  // One iteration of the datapath.
  logic [XLEN:0]   sum, sh;
  logic [XLEN-1:0] addend;
  always_comb begin
    addend = lo[0] ? b_q : '0;
    sum    = {1'b0, acc[XLEN-1:0]} + {1'b0, addend};
    sh     = {acc[XLEN-1:0], lo[XLEN-1]};
    acc_n  = acc;
    lo_n   = lo;
    if (op_q[1]) begin
      // Restoring divide: shift in next dividend bit, subtract if it fits.
      if (sh >= {1'b0, b_q}) begin
        acc_n = sh - {1'b0, b_q};
        lo_n  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_n = sh;
        lo_n  = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // Shift-add: product bits leave acc and fill lo from the top.
      acc_n = {1'b0, sum[XLEN:1]};
      lo_n  = {sum[0], lo[XLEN-1:1]};
    end
  end

  // Final value selected on the edge entering DONE. For divide-by-zero the
  // datapath has not run yet, so lo still holds the latched dividend.
  always_comb begin
    if (div0)              fin = op_q[0] ? lo : '1;
    else if (op_q == 2'b00 || op_q == 2'b10) fin = lo_n;
    else                   fin = acc_n[XLEN-1:0];
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = CALC;
      CALC: if (div0 || count == LAST) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      b_q      <= '0;
      acc      <= '0;
      lo       <= '0;
      count    <= '0;
      rd_q     <= '0;
      div0     <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          b_q   <= rs2_data;
          lo    <= rs1_data;
          acc   <= '0;
          count <= '0;
          rd_q  <= rd_addr;
          div0  <= op[1] && (rs2_data == '0);
        end
        CALC: begin
          acc   <= acc_n;
          lo    <= lo_n;
          count <= count + 1'b1;
          if (state_n == DONE) result_q <= fin;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign wb_en  = done && (rd_q != '0);
  assign wb_reg = rd_q;
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] rs1_data, rs2_data, result;
  logic [4:0]  rd_addr, wb_reg;
  logic        busy, done, wb_en;

  int tests = 0, fails = 0;

  muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .result(result), .wb_reg(wb_reg), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic with RISC-V divide-by-zero rules.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op and wait for done. lat = number of edges after E0 until done
  // is seen. If poke >= 0, a junk start pulse is driven at that point in CALC.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int poke);
    int lat;
    logic [31:0] exp, res;
    int exp_lat;
    int busy_low;
    exp     = model(o, a, b);
    exp_lat = (o[1] && b == 0) ? 1 : 32;
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk);
    @(negedge clk);
    // Operands are latched; scramble inputs to prove it.
    start = 1'b0; op = 2'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
    lat = 0; busy_low = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_low++;
      start = (lat == poke);
      @(posedge clk); lat++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({name, ".busy_calc"}, 64'(busy_low), 64'd0);
    chk({name, ".result"}, {32'd0, result}, {32'd0, exp});
    chk({name, ".wb_reg"}, 64'(wb_reg), 64'(rd));
    chk({name, ".wb_en"}, 64'(wb_en), 64'(rd != 0));
    chk({name, ".busy_done"}, 64'(busy), 64'd1);
    res = result;
    @(negedge clk);
    chk({name, ".idle"}, {61'd0, busy, done, wb_en}, 64'd0);
    chk({name, ".hold"}, {27'd0, wb_reg, result}, {27'd0, rd, res});
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'b00, 32'd7,          32'd6,          5'd5,  32'h0000_002A};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE};
    vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001};
    vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd3,  32'd14};
    vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd4,  32'd2};
    vecs[5] = '{2'b10, 32'hAABB_CCDD,  32'd1,          5'd31, 32'hAABB_CCDD};
    vecs[6] = '{2'b10, 32'd5,          32'd0,          5'd6,  32'hFFFF_FFFF};
    vecs[7] = '{2'b11, 32'd5,          32'd0,          5'd7,  32'd5};
    vecs[8] = '{2'b11, 32'd3,          32'd1000,       5'd8,  32'd3};

    reset = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.outputs", {61'd0, busy, done, wb_en}, 64'd0);
    chk("reset.result", 64'(result), 64'd0);
    chk("reset.wb_reg", 64'(wb_reg), 64'd0);
    reset = 1'b0;

    // Table: confirm the model agrees with hand-derived expectations, then run.
    foreach (vecs[i]) begin
      chk($sformatf("vec%0d.model", i), 64'(model(vecs[i].o, vecs[i].a, vecs[i].b)), 64'(vecs[i].exp));
      run_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].rd, -1);
    end

    // rd=0 suppresses write-back; a start pulse mid-CALC is ignored.
    run_op("rd0_poke", 2'b00, 32'd3, 32'd3, 5'd0, 5);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd9;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.result", 64'(result), 64'd0);
    chk("abort.wb", {58'd0, wb_reg, wb_en}, 64'd0);
    reset = 1'b0;
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || wb_en) seen++;
      end
      chk("abort.no_done", 64'(seen), 64'd0);
    end
    run_op("after_abort", 2'b00, 32'd2, 32'd2, 5'd10, -1);

    // Randomized ops against the model, including zero divisors and extremes.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), 2'($urandom), a, b, 5'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
